// File: rtl/mic_wcs_sequencer.sv
// rtl/mic_wcs_sequencer.sv - writable control store and microinstruction register for the MIC datapath
module mic_wcs_sequencer #(
  parameter int                ADDR_W    = 9,
  parameter int                WORD_W    = 39,
  parameter logic [WORD_W-1:0] NOP_WORD  = '0,
  parameter bit                PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mpc,
  input  logic              rd_en,
  input  logic              stall,
  input  logic              flush,
  input  logic              load_req,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  output logic [WORD_W-1:0] mir,
  output logic              mir_valid,
  output logic [ADDR_W-1:0] next_addr,
  output logic [2:0]        jam,
  output logic              par_err,
  output logic [7:0]        err_cnt,
  output logic              busy_load
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int MEM_W = WORD_W + (PARITY_EN ? 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LOAD} state_t;

  logic [MEM_W-1:0]  mem [DEPTH];
  logic [MEM_W-1:0]  rd_word;
  logic [MEM_W-1:0]  wr_word;
  logic              word_bad;
  logic              fetch;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] mir_q, mir_d;
  logic              mir_valid_q, mir_valid_d;
  logic              par_err_q, par_err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  // Stored parity sits in the MSB so a good word XORs to zero across all bits.
  generate
    if (PARITY_EN) begin : g_par
      assign wr_word = {^wr_data, wr_data};
    end else begin : g_nopar
      assign wr_word = wr_data;
    end
  endgenerate

  assign rd_word  = mem[mpc];
  assign word_bad = PARITY_EN && (^rd_word);

  always_comb begin
    state_d     = state_q;
    mir_d       = mir_q;
    mir_valid_d = mir_valid_q;
    par_err_d   = 1'b0;
    err_cnt_d   = err_cnt_q;
    fetch       = 1'b0;
    if (state_q == S_LOAD) begin
      mir_d       = NOP_WORD;
      mir_valid_d = 1'b0;
      if (!load_req) state_d = S_IDLE;
    end else if (load_req) begin
      state_d     = S_LOAD;
      mir_d       = NOP_WORD;
      mir_valid_d = 1'b0;
    end else begin
      if (rd_en) state_d = S_RUN;
      if (flush) begin
        mir_d       = NOP_WORD;
        mir_valid_d = 1'b0;
      end else if (!stall) begin
        if (rd_en) begin
          fetch       = 1'b1;
          mir_d       = rd_word[WORD_W-1:0];
          mir_valid_d = 1'b1;
        end else begin
          mir_valid_d = 1'b0;
        end
      end
    end
    // A bad word is still latched; the error is only reported and counted.
    if (fetch && word_bad) begin
      par_err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mir_q       <= NOP_WORD;
      mir_valid_q <= 1'b0;
      par_err_q   <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      mir_q       <= mir_d;
      mir_valid_q <= mir_valid_d;
      par_err_q   <= par_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // The array is deliberately outside the reset domain so completed loads survive reset.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && wr_valid) mem[wr_addr] <= wr_word;
  end

  assign wr_ready  = (state_q == S_LOAD);
  assign busy_load = (state_q == S_LOAD);
  assign mir       = mir_q;
  assign mir_valid = mir_valid_q;
  assign par_err   = par_err_q;
  assign err_cnt   = err_cnt_q;
  assign next_addr = mir_q[WORD_W-1 -: ADDR_W];
  assign jam       = mir_q[WORD_W-ADDR_W-1 -: 3];

endmodule

// File: tb/tb_mic_wcs_sequencer.sv
// tb/tb_mic_wcs_sequencer.sv - self-checking bench for mic_wcs_sequencer
module tb_mic_wcs_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  mpc;
  logic        rd_en, stall, flush, load_req, wr_valid;
  logic        wr_ready;
  logic [8:0]  wr_addr;
  logic [38:0] wr_data;
  logic [38:0] mir;
  logic        mir_valid;
  logic [8:0]  next_addr;
  logic [2:0]  jam;
  logic        par_err;
  logic [7:0]  err_cnt;
  logic        busy_load;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        rd, st, fl, lr, wv;
    logic [8:0]  mpc, waddr;
    logic [38:0] wdata;
    logic [38:0] e_mir;
    logic        e_val, e_perr, e_load;
  } vec_t;

  typedef struct {
    logic [38:0] mir;
    logic        val, perr, load;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];

  mic_wcs_sequencer dut (
    .clk(clk), .reset(reset), .mpc(mpc), .rd_en(rd_en), .stall(stall), .flush(flush),
    .load_req(load_req), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .mir(mir), .mir_valid(mir_valid), .next_addr(next_addr), .jam(jam),
    .par_err(par_err), .err_cnt(err_cnt), .busy_load(busy_load)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [38:0] pat(input int i);
    logic [8:0] a;
    a = 9'(i);
    return {a ^ 9'h0A5, 30'(i * 32'h0100_1003)};
  endfunction

  function automatic vec_t mk(input logic rd, st, fl, lr, input logic [8:0] a,
                              input logic [38:0] em, input logic ev, ep, el);
    vec_t v;
    v.rd = rd; v.st = st; v.fl = fl; v.lr = lr; v.wv = 1'b0;
    v.mpc = a; v.waddr = '0; v.wdata = '0;
    v.e_mir = em; v.e_val = ev; v.e_perr = ep; v.e_load = el;
    return v;
  endfunction

  function automatic vec_t mkw(input logic lr, input logic [8:0] wa, input logic [38:0] wd,
                               input logic el);
    vec_t v;
    v = mk(1'b0, 1'b0, 1'b0, lr, 9'd0, 39'd0, 1'b0, 1'b0, el);
    v.wv = 1'b1; v.waddr = wa; v.wdata = wd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic step(input vec_t v, input string tag);
    exp_t e;
    rd_en = v.rd; stall = v.st; flush = v.fl; load_req = v.lr; mpc = v.mpc;
    wr_valid = v.wv; wr_addr = v.waddr; wr_data = v.wdata;
    sb.push_back('{mir: v.e_mir, val: v.e_val, perr: v.e_perr, load: v.e_load});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".mir"}, 64'(mir), 64'(e.mir));
    chk({tag, ".mir_valid"}, 64'(mir_valid), 64'(e.val));
    chk({tag, ".par_err"}, 64'(par_err), 64'(e.perr));
    chk({tag, ".busy_load"}, 64'(busy_load), 64'(e.load));
    chk({tag, ".wr_ready"}, 64'(wr_ready), 64'(e.load));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".mir"}, 64'(mir), 64'd0);
    chk({tag, ".mir_valid"}, 64'(mir_valid), 64'd0);
    chk({tag, ".wr_ready"}, 64'(wr_ready), 64'd0);
    chk({tag, ".par_err"}, 64'(par_err), 64'd0);
    chk({tag, ".err_cnt"}, 64'(err_cnt), 64'd0);
    chk({tag, ".busy_load"}, 64'(busy_load), 64'd0);
    chk({tag, ".next_addr"}, 64'(next_addr), 64'd0);
    chk({tag, ".jam"}, 64'(jam), 64'd0);
  endtask

  localparam logic [38:0] W0   = 39'h12_3456_789A;
  localparam logic [38:0] WMAX = 39'h7F_FFFF_FFFF;

  initial begin
    logic [38:0] w;
    int          exp_cnt;

    reset = 1'b0;
    rd_en = 0; stall = 0; flush = 0; load_req = 0; wr_valid = 0;
    mpc = '0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 512; i++) begin
      w = (i == 0) ? W0 : pat(i);
      dut.mem[i] = {^w, w};
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;

    step(mk(1, 0, 0, 0, 9'd0, W0, 1, 0, 0), "fetch0");

    tbl.push_back(mk(1, 0, 0, 0, 9'd3,   pat(3),   1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 9'd511, pat(511), 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 9'd4,   pat(511), 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 9'd7,   pat(7),   1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 9'd7,   39'd0,    0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 9'd8,   39'd0,    0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 9'd8,   pat(8),   1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 9'd9,   39'd0,    0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 9'd9,   pat(9),   1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 9'd10,  pat(9),   1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 9'd11,  pat(9),   1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 9'd12,  pat(9),   1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 9'd13,  pat(13),  1, 0, 0));
    foreach (tbl[i]) step(tbl[i], $sformatf("tbl%0d", i));

    // Load mode: overwrite top word, double-write one address.
    step(mk(0, 0, 0, 1, 9'd0, 39'd0, 0, 0, 1), "load_enter");
    step(mkw(1, 9'h1FF, WMAX, 1), "load_w1ff");
    step(mkw(1, 9'd20, 39'h01_1111_1111, 1), "load_w20a");
    step(mkw(1, 9'd20, 39'h02_2222_2222, 1), "load_w20b");
    step(mk(0, 0, 0, 0, 9'd0, 39'd0, 0, 0, 0), "load_exit");
    step(mk(1, 0, 0, 0, 9'h1FF, WMAX, 1, 0, 0), "raw_1ff");
    chk("raw_1ff.next_addr", 64'(next_addr), 64'h1FF);
    chk("raw_1ff.jam", 64'(jam), 64'h7);
    step(mk(1, 0, 0, 0, 9'd20, 39'h02_2222_2222, 1, 0, 0), "raw_20");

    // load_req wins over rd_en from RUN.
    step(mk(1, 0, 0, 1, 9'd3, 39'd0, 0, 0, 1), "lr_rd");
    step(mk(1, 0, 0, 0, 9'd3, 39'd0, 0, 0, 0), "lr_exit");
    step(mk(1, 0, 0, 0, 9'd3, pat(3), 1, 0, 0), "post_load");

    // Parity corruption at address 5.
    dut.mem[5][39] = ~dut.mem[5][39];
    step(mk(1, 0, 0, 0, 9'd5, pat(5), 1, 1, 0), "bad5");
    chk("bad5.err_cnt", 64'(err_cnt), 64'd1);
    step(mk(1, 0, 0, 0, 9'd3, pat(3), 1, 0, 0), "good3");
    chk("good3.err_cnt", 64'(err_cnt), 64'd1);
    exp_cnt = 1;
    for (int k = 0; k < 300; k++) begin
      step(mk(1, 0, 0, 0, 9'd5, pat(5), 1, 1, 0), $sformatf("bad_loop%0d", k));
      if (exp_cnt < 255) exp_cnt++;
      chk($sformatf("bad_loop%0d.err_cnt", k), 64'(err_cnt), 64'(exp_cnt));
    end
    step(mk(1, 1, 0, 0, 9'd5, pat(5), 1, 0, 0), "bad_stall");
    step(mk(1, 0, 1, 0, 9'd5, 39'd0, 0, 0, 0), "bad_flush");
    chk("sat.err_cnt", 64'(err_cnt), 64'd255);

    // Reset in the middle of a four-beat load.
    step(mk(0, 0, 0, 1, 9'd0, 39'd0, 0, 0, 1), "mid_enter");
    step(mkw(1, 9'd40, 39'h0A_AAAA_0040, 1), "mid_w40");
    step(mkw(1, 9'd41, 39'h0B_BBBB_0041, 1), "mid_w41");
    load_req = 1'b1; wr_valid = 1'b1; wr_addr = 9'd42; wr_data = 39'h0C_CCCC_0042;
    reset = 1'b0;
    #2;
    check_reset_outputs("mid_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(mkw(0, 9'd42, 39'h0C_CCCC_0042, 0), "mid_w42");
    step(mkw(0, 9'd43, 39'h0D_DDDD_0043, 0), "mid_w43");
    step(mk(1, 0, 0, 0, 9'd40, 39'h0A_AAAA_0040, 1, 0, 0), "keep40");
    step(mk(1, 0, 0, 0, 9'd41, 39'h0B_BBBB_0041, 1, 0, 0), "keep41");
    step(mk(1, 0, 0, 0, 9'd42, pat(42), 1, 0, 0), "old42");
    step(mk(1, 0, 0, 0, 9'd43, pat(43), 1, 0, 0), "old43");
    chk("post_reset.err_cnt", 64'(err_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
